// File: rtl/ttrng_debias_packer_if.sv
// Byte stream leaving the debias packer: head-of-FIFO data with a valid/ready handshake.
interface ttrng_debias_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ttrng_debias_packer.sv
// Conditioning stage for raw ttrng bits: repetition-count health test, von Neumann
// debiasing, byte assembly and a small first-word-fall-through output FIFO.
module ttrng_debias_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        raw_bit,
  input  logic                        raw_valid,
  input  logic                        clear,
  ttrng_debias_packer_if.master       out_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        health_fail
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  logic          last_bit_q, last_bit_d;
  logic [RW-1:0] run_q, run_d;
  logic          health_fail_q, health_fail_d;
  logic          overflow_q, overflow_d;
  logic          half_q, half_d;
  logic          first_q, first_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          sample;
  logic [RW-1:0] run_base;
  logic          run_same;
  logic [RW-1:0] run_next;
  logic          trip;
  logic          pass;
  logic          emit;
  logic          byte_done;
  logic [7:0]    new_byte;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A clear in the same cycle as a sample makes that sample the first of a new run.
  assign sample    = ena && raw_valid && !health_fail_q;
  assign run_base  = clear ? '0 : run_q;
  assign run_same  = (run_base != '0) && (raw_bit == last_bit_q);
  assign run_next  = !run_same ? RW'(1)
                   : (run_base == RW'(RCT_CUTOFF)) ? run_base
                   : run_base + RW'(1);
  assign trip      = sample && (run_next == RW'(RCT_CUTOFF));
  assign pass      = sample && !trip;

  // Pair 10 yields 1 and pair 01 yields 0, so the emitted bit is the stored first half.
  assign emit      = pass && half_q && (first_q != raw_bit);
  assign byte_done = emit && (bit_cnt_q == 3'd7);
  assign new_byte  = {shift_q[6:0], first_q};

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && out_if.out_ready;
  assign push      = byte_done && (!full || pop);
  assign drop      = byte_done && full && !pop;

  always_comb begin
    last_bit_d    = last_bit_q;
    run_d         = run_q;
    health_fail_d = health_fail_q;
    overflow_d    = overflow_q;
    half_d        = half_q;
    first_d       = first_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (clear) begin
      run_d         = '0;
      health_fail_d = 1'b0;
      overflow_d    = 1'b0;
    end
    if (sample) begin
      last_bit_d = raw_bit;
      run_d      = run_next;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    // A tripped health test discards everything not yet handed to the consumer.
    if (trip) begin
      health_fail_d = 1'b1;
      half_d        = 1'b0;
      bit_cnt_d     = '0;
      shift_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (pass) begin
        if (!half_q) begin
          first_d = raw_bit;
          half_d  = 1'b1;
        end else begin
          half_d = 1'b0;
        end
      end
      if (emit) begin
        shift_d   = new_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bit_q    <= 1'b0;
      run_q         <= '0;
      health_fail_q <= 1'b0;
      overflow_q    <= 1'b0;
      half_q        <= 1'b0;
      first_q       <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      last_bit_q    <= last_bit_d;
      run_q         <= run_d;
      health_fail_q <= health_fail_d;
      overflow_q    <= overflow_d;
      half_q        <= half_d;
      first_q       <= first_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: empty entries are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_byte;
    end
  end

  assign out_if.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign out_if.out_valid = (count_q != '0);
  assign fifo_count       = count_q;
  assign overflow         = overflow_q;
  assign health_fail      = health_fail_q;

endmodule

// File: tb/tb_ttrng_debias_packer.sv
// Bench for ttrng_debias_packer: table-driven byte scenarios plus hand-written
// sequences for health trip, full-FIFO pop/push, enable gating and mid-byte reset.
module tb_ttrng_debias_packer;

  localparam int DEPTH  = 4;
  localparam int CUTOFF = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       raw_bit;
  logic       raw_valid;
  logic       clear;
  logic [2:0] fifoCount;
  logic       overflow;
  logic       healthFail;

  ttrng_debias_packer_if outIf ();

  ttrng_debias_packer #(.FIFO_DEPTH(DEPTH), .RCT_CUTOFF(CUTOFF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .clear       (clear),
    .out_if      (outIf),
    .fifo_count  (fifoCount),
    .overflow    (overflow),
    .health_fail (healthFail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dataByte;
    bit         junk;
    int         expCount;
    bit         expOverflow;
    bit         drainAfter;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] sb [$];
  int         modelCount = 0;
  int         compared   = 0;
  int         mismatched = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    raw_valid = 1'b1;
    raw_bit   = b;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic popAndCheck();
    logic [7:0] expByte;
    expByte = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    checkOutput("pop_valid", 32'(outIf.out_valid), 32'd1);
    checkOutput("pop_data", 32'(outIf.out_data), 32'(expByte));
    outIf.out_ready = 1'b1;
    tick();
    outIf.out_ready = 1'b0;
    if (modelCount > 0) modelCount--;
  endtask

  task automatic drain();
    while (sb.size() > 0) popAndCheck();
    checkOutput("drain_count", 32'(fifoCount), 32'd0);
    modelCount = 0;
  endtask

  // Each data bit becomes a raw pair {b, ~b}; junk pairs 00/11 go between data pairs.
  task automatic applyStimulus(input logic [7:0] b, input bit junk, input bit readyLast,
                               input bit expectAccept);
    for (int i = 7; i >= 0; i--) begin
      sendBit(b[i]);
      if (i == 0 && readyLast) begin
        checkOutput("prepop_valid", 32'(outIf.out_valid), 32'd1);
        checkOutput("prepop_data", 32'(outIf.out_data), 32'(sb.pop_front()));
        outIf.out_ready = 1'b1;
        modelCount--;
      end
      sendBit(~b[i]);
      outIf.out_ready = 1'b0;
      if (junk && i > 0) begin
        sendBit(1'b0); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
      end
    end
    if (expectAccept && modelCount < DEPTH) begin
      sb.push_back(b);
      modelCount++;
    end
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data"}, 32'(outIf.out_data), 32'd0);
    checkOutput({tag, "_valid"}, 32'(outIf.out_valid), 32'd0);
    checkOutput({tag, "_count"}, 32'(fifoCount), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_health"}, 32'(healthFail), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hAA, 1'b0, 1, 1'b0, 1'b1};
    vecs[1] = '{8'hAA, 1'b1, 1, 1'b0, 1'b1};
    vecs[2] = '{8'h0F, 1'b0, 1, 1'b0, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 2, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 1'b0, 3, 1'b0, 1'b0};
    vecs[5] = '{8'h0F, 1'b0, 4, 1'b0, 1'b0};
    vecs[6] = '{8'h0F, 1'b0, 4, 1'b1, 1'b1};

    rst_n = 1'b0; ena = 1'b1; raw_bit = 1'b0; raw_valid = 1'b0; clear = 1'b0;
    outIf.out_ready = 1'b0;
    repeat (2) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    // Plain pairs, junk-padded pairs, then filling past capacity.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].dataByte, vecs[v].junk, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_count", v), 32'(fifoCount), 32'(vecs[v].expCount));
      checkOutput($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].expOverflow));
      checkOutput($sformatf("vec%0d_health", v), 32'(healthFail), 32'd0);
      if (vecs[v].drainAfter) drain();
    end
    pulseClear();
    checkOutput("clear_overflow", 32'(overflow), 32'd0);

    // Repetition-count trip flushes a buffered byte and locks out further samples.
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b1);
    pulseClear();
    for (int i = 0; i < CUTOFF - 1; i++) sendBit(1'b1);
    checkOutput("rct_pre_health", 32'(healthFail), 32'd0);
    checkOutput("rct_pre_count", 32'(fifoCount), 32'd1);
    sendBit(1'b1);
    checkOutput("rct_trip_health", 32'(healthFail), 32'd1);
    checkOutput("rct_trip_count", 32'(fifoCount), 32'd0);
    checkOutput("rct_trip_valid", 32'(outIf.out_valid), 32'd0);
    checkOutput("rct_trip_data", 32'(outIf.out_data), 32'd0);
    sb.delete();
    modelCount = 0;
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0);
    checkOutput("rct_locked_count", 32'(fifoCount), 32'd0);
    checkOutput("rct_locked_health", 32'(healthFail), 32'd1);
    pulseClear();
    checkOutput("rct_clear_health", 32'(healthFail), 32'd0);
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b1);
    checkOutput("rct_after_count", 32'(fifoCount), 32'd1);
    drain();

    // Full FIFO with a pop on the completing edge keeps every byte in order.
    applyStimulus(8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h22, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h33, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h44, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
    checkOutput("fullpop_count", 32'(fifoCount), 32'd4);
    checkOutput("fullpop_overflow", 32'(overflow), 32'd0);
    drain();

    // Push and pop together at occupancy one.
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hC3, 1'b0, 1'b1, 1'b1);
    checkOutput("onepop_count", 32'(fifoCount), 32'd1);
    checkOutput("onepop_valid", 32'(outIf.out_valid), 32'd1);
    drain();

    // Samples arriving while disabled are ignored and the partial byte is kept.
    for (int i = 7; i >= 4; i--) begin
      sendBit(((8'hAA >> i) & 8'h01) != 0);
      sendBit(((8'hAA >> i) & 8'h01) == 0);
    end
    ena = 1'b0;
    for (int i = 0; i < 8; i++) sendBit(i[0]);
    ena = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      sendBit(((8'hAA >> i) & 8'h01) != 0);
      sendBit(((8'hAA >> i) & 8'h01) == 0);
    end
    sb.push_back(8'hAA);
    modelCount = 1;
    checkOutput("ena_count", 32'(fifoCount), 32'd1);
    drain();

    // Reset mid-byte with a byte already buffered, then a clean byte with latency checks.
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 2; i--) begin
      sendBit(((8'hAA >> i) & 8'h01) != 0);
      sendBit(((8'hAA >> i) & 8'h01) == 0);
    end
    rst_n = 1'b0;
    #2;
    checkAllZero("midreset");
    tick();
    checkAllZero("midreset_held");
    rst_n = 1'b1;
    sb.delete();
    modelCount = 0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      sendBit(((8'hAA >> i) & 8'h01) != 0);
      if (i == 0) checkOutput("latency_before_valid", 32'(outIf.out_valid), 32'd0);
      sendBit(((8'hAA >> i) & 8'h01) == 0);
    end
    checkOutput("latency_valid", 32'(outIf.out_valid), 32'd1);
    checkOutput("latency_count", 32'(fifoCount), 32'd1);
    sb.push_back(8'hAA);
    modelCount = 1;
    drain();
    repeat (3) tick();
    checkOutput("no_stale_count", 32'(fifoCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
